// File: rtl/dma_transfer_sequencer.sv
// Timing-and-control sequencer for an 8237-style DMA controller: HRQ/HLDA handshake,
// S0-S4 transfer states, DACK and strobe generation, TC/EOP completion and priority rotation.
module dma_transfer_sequencer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cpu_clock_posedge,
  input  logic       master_clear,
  input  logic [3:0] encoded_dma,
  input  logic [3:0] block_mode,
  input  logic [7:0] transfer_type,
  input  logic       compressed_timing,
  input  logic       extended_write,
  input  logic       terminal_count,
  input  logic       end_of_process_n,
  input  logic       hold_acknowledge,
  output logic       hold_request,
  output logic [3:0] dma_acknowledge_internal,
  output logic [1:0] dma_rotate,
  output logic       end_of_process_internal,
  output logic       address_enable,
  output logic       address_strobe,
  output logic       count_update,
  output logic       io_read_n,
  output logic       io_write_n,
  output logic       memory_read_n,
  output logic       memory_write_n
);

  typedef enum logic [2:0] {StSi, StS0, StS1, StS2, StS3, StS4} state_e;

  state_e     state_q;
  logic [1:0] chan_q;
  logic       hrq_q, eop_q, aen_q, adstb_q, cu_q;
  logic [3:0] dack_q;
  logic [1:0] rot_q;
  logic       ior_n_q, iow_n_q, memr_n_q, memw_n_q;

  logic [1:0] grant_idx;
  logic [1:0] act_type;
  logic       io_to_mem, mem_to_io, in_xfer, done;

  // Lowest set bit wins if the encoder ever presents more than one grant.
  always_comb begin
    grant_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (encoded_dma[i]) grant_idx = 2'(i);
    end
  end

  always_comb begin
    act_type  = transfer_type[{chan_q, 1'b0} +: 2];
    io_to_mem = (act_type == 2'b01);
    mem_to_io = (act_type == 2'b10);
    in_xfer   = (state_q == StS1) || (state_q == StS2) || (state_q == StS3) ||
                (state_q == StS4);
    done      = terminal_count || !end_of_process_n;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StSi;
      chan_q   <= 2'd0;
      hrq_q    <= 1'b0;
      dack_q   <= 4'd0;
      rot_q    <= 2'd0;
      eop_q    <= 1'b0;
      aen_q    <= 1'b0;
      adstb_q  <= 1'b0;
      cu_q     <= 1'b0;
      ior_n_q  <= 1'b1;
      iow_n_q  <= 1'b1;
      memr_n_q <= 1'b1;
      memw_n_q <= 1'b1;
    end else if (master_clear) begin
      state_q  <= StSi;
      chan_q   <= 2'd0;
      hrq_q    <= 1'b0;
      dack_q   <= 4'd0;
      rot_q    <= 2'd0;
      eop_q    <= 1'b0;
      aen_q    <= 1'b0;
      adstb_q  <= 1'b0;
      cu_q     <= 1'b0;
      ior_n_q  <= 1'b1;
      iow_n_q  <= 1'b1;
      memr_n_q <= 1'b1;
      memw_n_q <= 1'b1;
    end else begin
      // Pulses are set only on qualified edges and always clear on the next clock.
      cu_q  <= 1'b0;
      eop_q <= 1'b0;
      if (cpu_clock_posedge) begin
        if (in_xfer && !hold_acknowledge) begin
          // Bus taken back: drop everything, leave rotation alone.
          state_q  <= StSi;
          hrq_q    <= 1'b0;
          dack_q   <= 4'd0;
          aen_q    <= 1'b0;
          adstb_q  <= 1'b0;
          ior_n_q  <= 1'b1;
          iow_n_q  <= 1'b1;
          memr_n_q <= 1'b1;
          memw_n_q <= 1'b1;
        end else begin
          case (state_q)
            StSi: begin
              if (|encoded_dma) begin
                state_q <= StS0;
                hrq_q   <= 1'b1;
              end
            end
            StS0: begin
              if (hold_acknowledge && (|encoded_dma)) begin
                state_q <= StS1;
                chan_q  <= grant_idx;
                dack_q  <= 4'b0001 << grant_idx;
                aen_q   <= 1'b1;
                adstb_q <= 1'b1;
              end else if (!(|encoded_dma)) begin
                state_q <= StSi;
                hrq_q   <= 1'b0;
              end
            end
            StS1: begin
              state_q  <= StS2;
              adstb_q  <= 1'b0;
              ior_n_q  <= !io_to_mem;
              memr_n_q <= !mem_to_io;
              memw_n_q <= !(extended_write && io_to_mem);
              iow_n_q  <= !(extended_write && mem_to_io);
            end
            StS2: begin
              state_q  <= compressed_timing ? StS4 : StS3;
              cu_q     <= compressed_timing;
              memw_n_q <= !io_to_mem;
              iow_n_q  <= !mem_to_io;
            end
            StS3: begin
              state_q  <= StS4;
              cu_q     <= 1'b1;
              memw_n_q <= !io_to_mem;
              iow_n_q  <= !mem_to_io;
            end
            StS4: begin
              if (!done && block_mode[chan_q]) begin
                // Next block cycle: read strobe (and early write) re-assert for S2.
                state_q  <= StS2;
                ior_n_q  <= !io_to_mem;
                memr_n_q <= !mem_to_io;
                memw_n_q <= !(extended_write && io_to_mem);
                iow_n_q  <= !(extended_write && mem_to_io);
              end else begin
                state_q  <= StSi;
                eop_q    <= done;
                hrq_q    <= 1'b0;
                dack_q   <= 4'd0;
                aen_q    <= 1'b0;
                rot_q    <= chan_q + 2'd1;
                ior_n_q  <= 1'b1;
                iow_n_q  <= 1'b1;
                memr_n_q <= 1'b1;
                memw_n_q <= 1'b1;
              end
            end
            default: state_q <= StSi;
          endcase
        end
      end
    end
  end

  assign hold_request             = hrq_q;
  assign dma_acknowledge_internal = dack_q;
  assign dma_rotate               = rot_q;
  assign end_of_process_internal  = eop_q;
  assign address_enable           = aen_q;
  assign address_strobe           = adstb_q;
  assign count_update             = cu_q;
  assign io_read_n                = ior_n_q;
  assign io_write_n               = iow_n_q;
  assign memory_read_n            = memr_n_q;
  assign memory_write_n           = memw_n_q;

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// Bench for dma_transfer_sequencer: directed corner cases plus randomized transfers checked
// against a per-transaction expected output sequence derived from the transfer rules.
module tb_dma_transfer_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       cpu_clock_posedge = 1'b0;
  logic       master_clear = 1'b0;
  logic [3:0] encoded_dma = 4'd0;
  logic [3:0] block_mode = 4'd0;
  logic [7:0] transfer_type = 8'd0;
  logic       compressed_timing = 1'b0;
  logic       extended_write = 1'b0;
  logic       terminal_count = 1'b0;
  logic       end_of_process_n = 1'b1;
  logic       hold_acknowledge = 1'b0;

  logic       hold_request, end_of_process_internal, address_enable, address_strobe;
  logic       count_update, io_read_n, io_write_n, memory_read_n, memory_write_n;
  logic [3:0] dma_acknowledge_internal;
  logic [1:0] dma_rotate;

  int n_checks = 0;
  int n_fail = 0;
  logic [1:0] rot_m = 2'd0;

  localparam logic [14:0] ResetVec = 15'h000F;

  dma_transfer_sequencer dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .cpu_clock_posedge       (cpu_clock_posedge),
    .master_clear            (master_clear),
    .encoded_dma             (encoded_dma),
    .block_mode              (block_mode),
    .transfer_type           (transfer_type),
    .compressed_timing       (compressed_timing),
    .extended_write          (extended_write),
    .terminal_count          (terminal_count),
    .end_of_process_n        (end_of_process_n),
    .hold_acknowledge        (hold_acknowledge),
    .hold_request            (hold_request),
    .dma_acknowledge_internal(dma_acknowledge_internal),
    .dma_rotate              (dma_rotate),
    .end_of_process_internal (end_of_process_internal),
    .address_enable          (address_enable),
    .address_strobe          (address_strobe),
    .count_update            (count_update),
    .io_read_n               (io_read_n),
    .io_write_n              (io_write_n),
    .memory_read_n           (memory_read_n),
    .memory_write_n          (memory_write_n)
  );

  always #5 clock = ~clock;

  // {hrq, dack[3:0], rot[1:0], eop, aen, adstb, cu, ior_n, iow_n, memr_n, memw_n}
  logic [14:0] obs;
  assign obs = {hold_request, dma_acknowledge_internal, dma_rotate, end_of_process_internal,
                address_enable, address_strobe, count_update, io_read_n, io_write_n,
                memory_read_n, memory_write_n};

  task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] vec(input logic hrq, input logic [3:0] dack,
                                      input logic [1:0] rot, input logic eop, input logic aen,
                                      input logic adstb, input logic cu, input logic [3:0] stb);
    return {hrq, dack, rot, eop, aen, adstb, cu, stb};
  endfunction

  // Strobes for a phase: type 01 is IO read + memory write, type 10 is memory read + IO write.
  function automatic logic [3:0] stb(input logic rd, input logic wr, input logic [1:0] t);
    return {~(rd && t == 2'b01), ~(wr && t == 2'b10), ~(rd && t == 2'b10),
            ~(wr && t == 2'b01)};
  endfunction

  // One qualified DMA edge, then an unqualified clock on which only the pulses may change.
  task automatic qedge(input string tag, input logic [14:0] exp);
    @(negedge clock);
    cpu_clock_posedge = 1'b1;
    @(posedge clock);
    #1;
    check_eq(tag, obs, exp);
    @(negedge clock);
    cpu_clock_posedge = 1'b0;
    @(posedge clock);
    #1;
    check_eq({tag, "_hold"}, obs, exp & ~15'h0090);
    repeat ($urandom_range(0, 1)) @(posedge clock);
    #1;
  endtask

  task automatic abort_edge();
    hold_acknowledge = 1'b0;
    terminal_count   = 1'($urandom);
    end_of_process_n = 1'($urandom);
    qedge("abort", vec(1'b0, 4'd0, rot_m, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF));
    terminal_count   = 1'b0;
    end_of_process_n = 1'b1;
    encoded_dma      = 4'd0;
    qedge("idle_after_abort", vec(1'b0, 4'd0, rot_m, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF));
  endtask

  task automatic run_xfer(input bit may_abort);
    int ch, iters, abort_at, k, dly, sel;
    logic [1:0] t;
    logic [3:0] oh;
    logic blk, comp, ext, done;
    ch                = $urandom_range(0, 3);
    transfer_type     = 8'($urandom);
    block_mode        = 4'($urandom);
    comp              = 1'($urandom);
    ext               = 1'($urandom);
    compressed_timing = comp;
    extended_write    = ext;
    t                 = transfer_type[2*ch +: 2];
    blk               = block_mode[ch];
    iters             = blk ? $urandom_range(1, 3) : 1;
    oh                = 4'b0001 << ch;
    abort_at          = (may_abort && ($urandom_range(0, 3) == 0)) ?
                        $urandom_range(0, iters * (comp ? 2 : 3)) : -1;
    terminal_count    = 1'b0;
    end_of_process_n  = 1'b1;
    hold_acknowledge  = 1'b0;
    encoded_dma       = oh;
    qedge("req", vec(1'b1, 4'd0, rot_m, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF));
    dly = $urandom_range(0, 3);
    repeat (dly) qedge("wait_hlda", vec(1'b1, 4'd0, rot_m, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF));
    hold_acknowledge = 1'b1;
    qedge("s1", vec(1'b1, oh, rot_m, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF));
    k = 0;
    for (int i = 0; i < iters; i++) begin
      if (k++ == abort_at) begin abort_edge(); return; end
      encoded_dma = 4'($urandom);
      qedge("s2", vec(1'b1, oh, rot_m, 1'b0, 1'b1, 1'b0, 1'b0, stb(1'b1, ext, t)));
      if (!comp) begin
        if (k++ == abort_at) begin abort_edge(); return; end
        qedge("s3", vec(1'b1, oh, rot_m, 1'b0, 1'b1, 1'b0, 1'b0, stb(1'b1, 1'b1, t)));
      end
      if (k++ == abort_at) begin abort_edge(); return; end
      qedge("s4", vec(1'b1, oh, rot_m, 1'b0, 1'b1, 1'b0, 1'b1, stb(1'b1, 1'b1, t)));
    end
    if (k == abort_at) begin abort_edge(); return; end
    done = blk ? 1'b1 : 1'($urandom);
    if (done) begin
      sel = $urandom_range(0, 2);
      terminal_count   = (sel != 1);
      end_of_process_n = (sel == 0);
    end
    rot_m = 2'(ch + 1);
    qedge("exit", vec(1'b0, 4'd0, rot_m, done, 1'b0, 1'b0, 1'b0, 4'hF));
    terminal_count   = 1'b0;
    end_of_process_n = 1'b1;
    encoded_dma      = 4'd0;
    hold_acknowledge = 1'b0;
    qedge("idle", vec(1'b0, 4'd0, rot_m, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF));
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1 check_eq("reset", obs, ResetVec);
    @(negedge clock);
    reset_n = 1'b1;

    // Grant withdrawn before HLDA: HRQ drops, DACK never appears.
    encoded_dma = 4'b0010;
    qedge("wd_req", vec(1'b1, 4'd0, rot_m, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF));
    encoded_dma = 4'd0;
    qedge("wd_drop", vec(1'b0, 4'd0, rot_m, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF));

    for (int n = 0; n < 60; n++) run_xfer(1'b1);

    // master_clear mid-transfer acts without a qualified edge and clears the rotation.
    encoded_dma      = 4'b0001;
    hold_acknowledge = 1'b1;
    qedge("mc_req", vec(1'b1, 4'd0, rot_m, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF));
    qedge("mc_s1", vec(1'b1, 4'b0001, rot_m, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF));
    @(negedge clock);
    master_clear = 1'b1;
    @(posedge clock);
    #1 check_eq("master_clear", obs, ResetVec);
    master_clear = 1'b0;
    encoded_dma  = 4'd0;
    rot_m        = 2'd0;

    for (int n = 0; n < 20; n++) run_xfer(1'b1);

    // Async reset while in S3 of a read transfer on channel 3.
    transfer_type     = 8'b1000_0000;
    block_mode        = 4'd0;
    compressed_timing = 1'b0;
    extended_write    = 1'b0;
    encoded_dma       = 4'b1000;
    hold_acknowledge  = 1'b0;
    qedge("ar_req", vec(1'b1, 4'd0, rot_m, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF));
    hold_acknowledge = 1'b1;
    qedge("ar_s1", vec(1'b1, 4'b1000, rot_m, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF));
    qedge("ar_s2", vec(1'b1, 4'b1000, rot_m, 1'b0, 1'b1, 1'b0, 1'b0, stb(1'b1, 1'b0, 2'b10)));
    qedge("ar_s3", vec(1'b1, 4'b1000, rot_m, 1'b0, 1'b1, 1'b0, 1'b0, stb(1'b1, 1'b1, 2'b10)));
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check_eq("async_reset", obs, ResetVec);
    @(negedge clock);
    reset_n          = 1'b1;
    encoded_dma      = 4'd0;
    hold_acknowledge = 1'b0;
    rot_m            = 2'd0;

    for (int n = 0; n < 10; n++) run_xfer(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
